hist_lane_ctrl: RTL and testbench

- Sequencing controller for one histogram lane (single-port-pair BRAM incrementer with `hist_read`/`hist_rst` controls and 2-cycle read latency).
- Owns the lane's address/valid inputs and multiplexes three sources: live event addresses (ACQUIRE), a readout sweep that streams every bin out over a ready/valid interface with backpressure, and a clear sweep that zeroes all bins.
- Sits between the event-to-bin mapping stage and the readout/DMA stream.

---
 rtl/hist_lane_ctrl_if.sv | 26 ++
 rtl/hist_lane_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_hist_lane_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_lane_ctrl_if.sv
// ---------------------------------------------------------------------------
// hist_lane_ctrl_if
//   Ready/valid readout stream that carries histogram bins from the lane
//   controller to the readout/DMA consumer.
//
//   Signals:
//     m_data   bin value (DATA_WIDTH bits)
//     m_valid  beat present
//     m_ready  consumer accepts the beat
//     m_last   beat carries the final bin of the sweep
//
//   Modports:
//     master  producer side (hist_lane_ctrl)
//     slave   consumer side
// ---------------------------------------------------------------------------
interface hist_lane_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/hist_lane_ctrl.sv
// ---------------------------------------------------------------------------
// hist_lane_ctrl
//   Sequencing controller for one histogram lane (BRAM incrementer with
//   hist_read / hist_rst controls and a 2-cycle read latency). It drives the
//   lane address/valid inputs from one of three sources:
//     - live event addresses while acquiring,
//     - a readout sweep that streams every bin out with backpressure,
//     - a clear sweep that zeroes every bin.
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     event_addr, event_valid    incoming events (no backpressure)
//     readout_req, clear_req     sweep start pulses (ignored while busy)
//     clear_on_read              sampled at readout start: zero bins as read
//     lane_address, lane_valid,
//     lane_hist_read,
//     lane_hist_rst              lane control outputs
//     lane_data, lane_valid_out,
//     lane_last                  lane read-back
//     m_stream                   readout stream (master side)
//     busy                       high whenever not acquiring
//     dropped_events             saturating count of events lost while busy
// ---------------------------------------------------------------------------
module hist_lane_ctrl #(
  parameter int HIST_MEM_DEPTH      = 4096,
  parameter int HIST_WORD_SIZE      = 32,
  parameter int HIST_MEM_ADDR_WIDTH = $clog2(HIST_MEM_DEPTH),
  parameter int FIFO_DEPTH          = 4,
  parameter int CLEAR_ON_RESET      = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic [HIST_MEM_ADDR_WIDTH-1:0] event_addr,
  input  logic                           event_valid,
  input  logic                           readout_req,
  input  logic                           clear_req,
  input  logic                           clear_on_read,

  output logic [HIST_MEM_ADDR_WIDTH-1:0] lane_address,
  output logic                           lane_valid,
  output logic                           lane_hist_read,
  output logic                           lane_hist_rst,
  input  logic [HIST_WORD_SIZE-1:0]      lane_data,
  input  logic                           lane_valid_out,
  input  logic                           lane_last,

  hist_lane_ctrl_if.master               m_stream,

  output logic                           busy,
  output logic [31:0]                    dropped_events
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CRW     = FIFO_AW + 2;
  localparam logic [CRW-1:0] CREDIT_LIMIT = CRW'(FIFO_DEPTH);
  localparam logic [HIST_MEM_ADDR_WIDTH-1:0] LAST_ADDR =
    HIST_MEM_ADDR_WIDTH'(HIST_MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_ACQUIRE,
    ST_DRAIN,
    ST_CLEAR_DRAIN,
    ST_SWEEP,
    ST_FLUSH,
    ST_WAIT_EMPTY,
    ST_CLEAR_SWEEP,
    ST_CLEAR_WAIT
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR_DRAIN : ST_ACQUIRE;

  state_t                         state_reg;
  logic [HIST_MEM_ADDR_WIDTH-1:0] counter_reg;
  logic                           wait_reg;       // second cycle of a 2-cycle wait
  logic                           col_reg;        // latched clear_on_read
  logic [1:0]                     inflight_reg;   // reads issued, data not yet back
  logic [31:0]                    dropped_reg;

  logic [HIST_WORD_SIZE-1:0]      fifo_data_mem [FIFO_DEPTH];
  logic                           fifo_last_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]             wr_ptr_reg;
  logic [FIFO_AW-1:0]             rd_ptr_reg;
  logic [FIFO_AW:0]               fifo_count_reg;

  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_has_data;
  logic [CRW-1:0]                 credit_used;
  logic                           issue;

  // A read is only issued when its data is guaranteed a FIFO slot, counting
  // both stored entries and reads still travelling through the lane.
  assign credit_used = {1'b0, fifo_count_reg} + {{FIFO_AW{1'b0}}, inflight_reg};
  assign issue       = (state_reg == ST_SWEEP) && (credit_used < CREDIT_LIMIT);

  assign fifo_has_data = (fifo_count_reg != '0);
  assign fifo_push     = lane_valid_out;
  assign fifo_pop      = fifo_has_data && m_stream.m_ready;

  // Head of the FIFO is read combinationally so a bin reaches m_data one
  // cycle after the lane returns it; the data is forced to zero when empty.
  assign m_stream.m_valid = fifo_has_data;
  assign m_stream.m_data  = fifo_has_data ? fifo_data_mem[rd_ptr_reg] : '0;
  assign m_stream.m_last  = fifo_has_data && fifo_last_mem[rd_ptr_reg];

  assign busy           = rst_n && (state_reg != ST_ACQUIRE);
  assign dropped_events = dropped_reg;

  // Lane controls. While acquiring the event path is passed straight through;
  // the whole bundle is held at zero while reset is asserted.
  always_comb begin
    lane_address   = counter_reg;
    lane_valid     = 1'b0;
    lane_hist_read = 1'b0;
    lane_hist_rst  = 1'b0;
    case (state_reg)
      ST_ACQUIRE: begin
        lane_address = event_addr;
        lane_valid   = event_valid;
      end
      ST_SWEEP: begin
        lane_hist_read = 1'b1;
        lane_hist_rst  = col_reg;
        lane_valid     = issue;
      end
      ST_FLUSH, ST_WAIT_EMPTY: begin
        lane_hist_read = 1'b1;
        lane_hist_rst  = col_reg;
      end
      ST_CLEAR_SWEEP: begin
        lane_hist_rst = 1'b1;
        lane_valid    = 1'b1;
      end
      ST_CLEAR_WAIT: begin
        lane_hist_rst = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      lane_address   = '0;
      lane_valid     = 1'b0;
      lane_hist_read = 1'b0;
      lane_hist_rst  = 1'b0;
    end
  end

  // FIFO storage has no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_mem[wr_ptr_reg] <= lane_data;
      fifo_last_mem[wr_ptr_reg] <= lane_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RESET_STATE;
      counter_reg    <= '0;
      wait_reg       <= 1'b0;
      col_reg        <= 1'b0;
      inflight_reg   <= '0;
      dropped_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (event_valid && (state_reg != ST_ACQUIRE) && (dropped_reg != '1)) begin
        dropped_reg <= dropped_reg + 32'd1;
      end

      case ({issue, lane_valid_out})
        2'b10:   inflight_reg <= inflight_reg + 2'd1;
        2'b01:   inflight_reg <= inflight_reg - 2'd1;
        default: ;
      endcase

      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: ;
      endcase

      case (state_reg)
        ST_ACQUIRE: begin
          wait_reg <= 1'b0;
          if (clear_req) begin
            state_reg <= ST_CLEAR_DRAIN;
          end else if (readout_req) begin
            state_reg <= ST_DRAIN;
            col_reg   <= clear_on_read;
          end
        end
        // Two idle cycles let increments already in the lane pipeline land
        // before hist_read starts suppressing writes.
        ST_DRAIN, ST_CLEAR_DRAIN: begin
          if (wait_reg) begin
            wait_reg    <= 1'b0;
            counter_reg <= '0;
            state_reg   <= (state_reg == ST_DRAIN) ? ST_SWEEP : ST_CLEAR_SWEEP;
          end else begin
            wait_reg <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (issue) begin
            counter_reg <= counter_reg + 1'b1;
            if (counter_reg == LAST_ADDR) state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (lane_valid_out && lane_last) state_reg <= ST_WAIT_EMPTY;
        end
        // The final bin is the last FIFO entry, so its acceptance also
        // leaves the FIFO empty.
        ST_WAIT_EMPTY: begin
          if (fifo_pop && m_stream.m_last && (fifo_count_reg == 1)) begin
            state_reg <= ST_ACQUIRE;
          end
        end
        ST_CLEAR_SWEEP: begin
          counter_reg <= counter_reg + 1'b1;
          if (counter_reg == LAST_ADDR) begin
            state_reg <= ST_CLEAR_WAIT;
            wait_reg  <= 1'b0;
          end
        end
        ST_CLEAR_WAIT: begin
          if (wait_reg) begin
            wait_reg  <= 1'b0;
            state_reg <= ST_ACQUIRE;
          end else begin
            wait_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_ACQUIRE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_lane_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hist_lane_ctrl
//   Directed bench for hist_lane_ctrl with a behavioural histogram lane
//   (increment / clear / read with 2-cycle latency). Expected beats are
//   queued when a readout is issued; a negedge monitor pops and compares
//   every accepted stream beat.
// ---------------------------------------------------------------------------
module tb_hist_lane_ctrl;
  localparam int DEPTH = 16;
  localparam int WS    = 32;
  localparam int AW    = 4;
  localparam int FD    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] event_addr;
  logic          event_valid;
  logic          readout_req;
  logic          clear_req;
  logic          clear_on_read;
  logic [AW-1:0] lane_address;
  logic          lane_valid;
  logic          lane_hist_read;
  logic          lane_hist_rst;
  logic [WS-1:0] lane_data;
  logic          lane_valid_out;
  logic          lane_last;
  logic          busy;
  logic [31:0]   dropped_events;
  logic          m_ready_drv;

  hist_lane_ctrl_if #(.DATA_WIDTH(WS)) stream_if ();
  assign stream_if.m_ready = m_ready_drv;

  hist_lane_ctrl #(
    .HIST_MEM_DEPTH (DEPTH),
    .HIST_WORD_SIZE (WS),
    .FIFO_DEPTH     (FD),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .event_addr     (event_addr),
    .event_valid    (event_valid),
    .readout_req    (readout_req),
    .clear_req      (clear_req),
    .clear_on_read  (clear_on_read),
    .lane_address   (lane_address),
    .lane_valid     (lane_valid),
    .lane_hist_read (lane_hist_read),
    .lane_hist_rst  (lane_hist_rst),
    .lane_data      (lane_data),
    .lane_valid_out (lane_valid_out),
    .lane_last      (lane_last),
    .m_stream       (stream_if.master),
    .busy           (busy),
    .dropped_events (dropped_events)
  );

  initial forever #5 clk = ~clk;

  // ---------------- behavioural lane ----------------
  logic [WS-1:0] lane_mem [DEPTH];
  logic          s1_v, s1_rd, s1_rst;
  logic [AW-1:0] s1_a;

  initial begin
    for (int i = 0; i < DEPTH; i++) lane_mem[i] = 32'hDEAD_0000 + i;
    s1_v = 1'b0; s1_rd = 1'b0; s1_rst = 1'b0; s1_a = '0;
    lane_valid_out = 1'b0; lane_data = '0; lane_last = 1'b0;
    forever begin
      @(posedge clk);
      s1_v   <= lane_valid;
      s1_a   <= lane_address;
      s1_rd  <= lane_hist_read;
      s1_rst <= lane_hist_rst;
      lane_valid_out <= s1_v && s1_rd;
      lane_data      <= lane_mem[s1_a];
      lane_last      <= (s1_a == AW'(DEPTH - 1));
      if (s1_v) begin
        if (s1_rd) begin
          if (s1_rst) lane_mem[s1_a] <= '0;
        end else if (s1_rst) begin
          lane_mem[s1_a] <= '0;
        end else begin
          lane_mem[s1_a] <= lane_mem[s1_a] + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [WS-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q [$];
  logic [WS-1:0] exp_bins [DEPTH];
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  beat_t         mon_exp;
  int            beat_cnt = 0;
  int            occ = 0, max_occ = 0;
  int            infl = 0, max_infl = 0;
  bit            prev_stall = 1'b0;
  logic [WS-1:0] prev_data;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      occ = 0; infl = 0; prev_stall = 1'b0;
    end else begin
      if (stream_if.m_valid && m_ready_drv) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0b, required no beat",
                   stream_if.m_data, stream_if.m_last);
        end else begin
          mon_exp = exp_q.pop_front();
          if (stream_if.m_data !== mon_exp.data || stream_if.m_last !== mon_exp.last) begin
            miscompares++;
            $display("FAIL beat_bin%0d: got data 0x%0h last %0b, required data 0x%0h last %0b",
                     beat_cnt % DEPTH, stream_if.m_data, stream_if.m_last,
                     mon_exp.data, mon_exp.last);
          end
          beat_cnt++;
        end
      end
      if (prev_stall && stream_if.m_valid && stream_if.m_data !== prev_data) begin
        miscompares++;
        $display("FAIL stall_hold: got 0x%0h, required 0x%0h", stream_if.m_data, prev_data);
      end
      prev_stall = stream_if.m_valid && !m_ready_drv;
      prev_data  = stream_if.m_data;
      occ = occ + int'(lane_valid_out) - int'(stream_if.m_valid && m_ready_drv);
      if (occ > max_occ) max_occ = occ;
      if (occ > FD) begin
        miscompares++;
        $display("FAIL fifo_overflow: got occupancy %0d, required <= %0d", occ, FD);
      end
      infl = infl + int'(lane_valid && lane_hist_read) - int'(lane_valid_out);
      if (infl > max_infl) max_infl = infl;
    end
  end

  // ---------------- stream ready driver ----------------
  bit       toggle_en = 1'b0;
  bit [3:0] pat_bits = 4'b1001;
  int       pidx = 0;

  initial begin
    m_ready_drv = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (toggle_en) begin
        m_ready_drv = pat_bits[pidx];
        pidx = (pidx + 1) % 4;
      end else begin
        m_ready_drv = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int clr_writes;
  bit addr_ok;
  int mv_seen;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Counts consecutive busy cycles; returns at the negedge where busy is low.
  task automatic wait_busy(output int n);
    bit done;
    n = 0; done = 1'b0; clr_writes = 0; addr_ok = 1'b1; mv_seen = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      n++;
      if (stream_if.m_valid) mv_seen++;
      if (lane_valid && lane_hist_rst && !lane_hist_read) begin
        if (lane_address != AW'(clr_writes)) addr_ok = 1'b0;
        clr_writes++;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: got busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic issue_readout(input bit col, input bit expect_beats);
    if (expect_beats)
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({exp_bins[i], i == DEPTH - 1});
    readout_req   = 1'b1;
    clear_on_read = col;
    tick();
    readout_req   = 1'b0;
    clear_on_read = 1'b0;
  endtask

  task automatic run_readout(input bit col, input string name);
    int n;
    issue_readout(col, 1'b1);
    wait_busy(n);
    check({name, "_all_beats"}, exp_q.size(), 0);
  endtask

  task automatic check_clear_sweep(input string name);
    int n;
    wait_busy(n);
    check({name, "_busy_cycles"}, n, 20);
    check({name, "_clear_writes"}, clr_writes, DEPTH);
    check({name, "_clear_addr_order"}, addr_ok, 1);
    check({name, "_no_stream"}, mv_seen, 0);
  endtask

  int ev_list [5] = '{3, 3, 3, 5, 3};

  initial begin
    int n;
    event_valid = 1'b0; event_addr = '0;
    readout_req = 1'b0; clear_req = 1'b0; clear_on_read = 1'b0;
    foreach (exp_bins[i]) exp_bins[i] = '0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_lane_valid", lane_valid, 0);
    check("rst_lane_hist_rst", lane_hist_rst, 0);
    check("rst_m_valid", stream_if.m_valid, 0);
    check("rst_dropped", dropped_events, 0);

    // 1: automatic clear after reset, then an all-zero readout
    rst_n = 1'b1;
    check_clear_sweep("t1_clear");
    tick();
    issue_readout(1'b0, 1'b1);
    wait_busy(n);
    check("t1_readout_busy_cycles", n, 21);
    check("t1_all_beats", exp_q.size(), 0);

    // 2: events 3,3,3,5,3 then readout immediately after
    foreach (ev_list[i]) begin
      tick();
      event_valid = 1'b1;
      event_addr  = AW'(ev_list[i]);
    end
    tick();
    event_valid = 1'b0;
    exp_bins[3] = 32'd4;
    exp_bins[5] = 32'd1;
    issue_readout(1'b0, 1'b1);
    wait_busy(n);
    check("t2_all_beats", exp_q.size(), 0);
    check("t2_dropped", dropped_events, 0);

    // 3: same contents, consumer ready toggling 1-0-0-1
    tick();
    toggle_en = 1'b1;
    run_readout(1'b0, "t3");
    toggle_en = 1'b0;

    // 4: 7 events to bin 15, clear-on-read pass, then all-zero pass
    for (int i = 0; i < 7; i++) begin
      tick();
      event_valid = 1'b1;
      event_addr  = AW'(15);
    end
    tick();
    event_valid  = 1'b0;
    exp_bins[15] = 32'd7;
    run_readout(1'b1, "t4_first");
    foreach (exp_bins[i]) exp_bins[i] = '0;
    tick();
    run_readout(1'b0, "t4_second");

    // 5: event_valid held through a readout; the request-cycle event counts
    tick();
    event_valid = 1'b1;
    event_addr  = AW'(7);
    exp_bins[7] = 32'd1;
    issue_readout(1'b0, 1'b1);
    wait_busy(n);
    event_valid = 1'b0;
    check("t5_busy_cycles", n, 21);
    check("t5_dropped", dropped_events, 21);
    check("t5_all_beats", exp_q.size(), 0);
    tick();
    run_readout(1'b0, "t5_recheck");

    // 6a: simultaneous requests -> clear only
    tick();
    readout_req = 1'b1;
    clear_req   = 1'b1;
    tick();
    readout_req = 1'b0;
    clear_req   = 1'b0;
    check_clear_sweep("t6_both_req");
    foreach (exp_bins[i]) exp_bins[i] = '0;

    // 6b: reset in the middle of a readout sweep
    tick();
    exp_bins[7] = 32'd0;
    issue_readout(1'b0, 1'b0);
    tick();
    tick();
    check("t6_sweep_hist_read", lane_hist_read, 1);
    check("t6_sweep_first_addr", lane_address, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_lane_valid", lane_valid, 0);
    check("t6_rst_lane_hist_read", lane_hist_read, 0);
    check("t6_rst_lane_address", lane_address, 0);
    check("t6_rst_m_valid", stream_if.m_valid, 0);
    check("t6_rst_dropped", dropped_events, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    check_clear_sweep("t6_post_rst_clear");
    tick();
    run_readout(1'b0, "t6_post_rst_readout");

    check("max_inflight_le_2", max_infl <= 2, 1);
    check("max_fifo_occ_le_depth", max_occ <= FD, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
